// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, LSB first, start/done handshake.
// Optional build macro SERIAL_SUB_EN adds a 'sub' port for a - b via two's complement.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] load_b;
  logic             load_c;

  // Full-adder cell fed by the operand LSBs and the carry flop
  always_comb begin
    fa_s    = shift_a[0] ^ shift_b[0] ^ carry;
    fa_cout = (shift_a[0] & shift_b[0]) | (carry & (shift_a[0] ^ shift_b[0]));
  end

  // Operand B and initial carry as loaded on the accept edge
  always_comb begin
`ifdef SERIAL_SUB_EN
    load_b = sub ? ~b : b;
    load_c = sub | c_in;
`else
    load_b = b;
    load_c = c_in;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      shift_a <= '0;
      shift_b <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            shift_a <= a;
            shift_b <= load_b;
            carry   <= load_c;
            cnt     <= '0;
            state   <= RUN;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Sum bits enter at the top of acc so bit 0 lands at acc[0] after WIDTH-1 shifts
          carry   <= fa_cout;
          acc     <= (WIDTH-1)'({fa_s, acc} >> 1);
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            sum   <= {fa_s, acc};
            c_out <= fa_cout;
            state <= DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed ops plus WIDTH=3 exhaustive sweep.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, c_out8;
  logic [7:0] sum8;
`ifdef SERIAL_SUB_EN
  logic       sub8 = 1'b0;
`endif

  logic       start3 = 1'b0, cin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       ready3, busy3, done3, c_out3;
  logic [2:0] sum3;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8)
`ifdef SERIAL_SUB_EN
    , .sub(sub8)
`endif
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .c_in(cin3),
    .ready(ready3), .busy(busy3), .done(done3), .sum(sum3), .c_out(c_out3)
`ifdef SERIAL_SUB_EN
    , .sub(1'b0)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [3:0] q3[$];
  logic [8:0] last8 = '0;
  logic [8:0] e8;
  logic [3:0] e3;
  logic       done8_q = 1'b0, done3_q = 1'b0;
  int         pulses3 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y,
                                        input logic c, input logic s);
    logic [7:0] ny;
    ny = ~y;
    if (s) return {1'b0, x} + {1'b0, ny} + 9'd1;
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Pop and compare whenever a result is presented
  always @(negedge clk) begin
    if (rst_n) begin
      if (done8) begin
        check("done8_one_cycle", {31'd0, done8_q}, 32'd0);
        if (q8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
        else begin
          e8 = q8.pop_front();
          check("result8", {23'd0, c_out8, sum8}, {23'd0, e8});
          last8 = e8;
        end
      end
      if (done3) begin
        pulses3++;
        check("done3_one_cycle", {31'd0, done3_q}, 32'd0);
        if (q3.size() == 0) check("done3_unexpected", 32'd1, 32'd0);
        else begin
          e3 = q3.pop_front();
          check("result3", {28'd0, c_out3, sum3}, {28'd0, e3});
        end
      end
      done8_q = done8;
      done3_q = done3;
    end else begin
      done8_q = 1'b0;
      done3_q = 1'b0;
    end
  end

  task automatic wait_done8(input string tag);
    int k;
    k = 0;
    while (!done8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, done8}, 32'd1);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts);
    int  k;
    bit  seen;
    @(negedge clk);
    k = 0;
    while (!ready8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready8_wait", {31'd0, ready8}, 32'd1);
    a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
`ifdef SERIAL_SUB_EN
    sub8 = ts;
`endif
    q8.push_back(model8(ta, tb_, tc, ts));
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~ta; b8 = ~tb_;
    check("run8_flags", {30'd0, ready8, busy8}, 32'd1);
    k = 1;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (done8) seen = 1'b1;
      else if (k == 8) begin
        check("run8_flags_late", {30'd0, ready8, busy8}, 32'd1);
        check("sum8_held", {23'd0, c_out8, sum8}, {23'd0, last8});
      end
    end
    check("latency8", k, 32'd9);
  endtask

  task automatic op3(input logic [2:0] ta, input logic [2:0] tb_, input logic tc);
    int k;
    @(negedge clk);
    k = 0;
    while (!ready3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    a3 = ta; b3 = tb_; cin3 = tc; start3 = 1'b1;
    q3.push_back({1'b0, ta} + {1'b0, tb_} + {3'd0, tc});
    @(negedge clk);
    start3 = 1'b0;
    k = 0;
    while (!done3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done3) check("done3_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_flags", {29'd0, ready8, busy8, done8}, 32'd4);
    check("rst_result", {23'd0, c_out8, sum8}, 32'd0);

    op8(8'h00, 8'h00, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1, 1'b0);
    op8(8'h7F, 8'h80, 1'b0, 1'b0);
    op8(8'h3C, 8'h0F, 1'b1, 1'b0);

    // Start held through RUN, then a back-to-back accept in the DONE cycle
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h003);
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22;
    q8.push_back(9'h033);
    wait_done8("bb_first_done");
    @(negedge clk);
    start8 = 1'b0;
    check("bb_done_drop", {31'd0, done8}, 32'd0);
    check("bb_busy_again", {30'd0, ready8, busy8}, 32'd1);
    check("bb_sum_held", {23'd0, c_out8, sum8}, 32'h003);
    wait_done8("bb_second_done");
    @(negedge clk);

    // Asynchronous reset three cycles into RUN
    a8 = 8'h55; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h088);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_flags", {29'd0, ready8, busy8, done8}, 32'd4);
    check("arst_result", {23'd0, c_out8, sum8}, 32'd0);
    q8.delete();
    last8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h10, 8'h20, 1'b0, 1'b0);

`ifdef SERIAL_SUB_EN
    op8(8'h05, 8'h07, 1'b0, 1'b1);
    op8(8'h07, 8'h05, 1'b1, 1'b1);
    op8(8'h07, 8'h05, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int c = 0; c < 2; c++)
          op3(3'(i), 3'(j), 1'(c));
    repeat (3) @(negedge clk);
    check("pulses3", pulses3, 32'd128);
    check("q3_drained", q3.size(), 32'd0);
    check("q8_drained", q8.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
